// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer and mid-bit sampling.
// Define UART_RX_FRAME_ERR_EN to add oRxFrameErr and reject frames with a low stop bit.
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iRxSerial,
  output logic [7:0] oRxByte,
  output logic       oRxDone
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       oRxFrameErr
`endif
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] clkCnt_q, clkCnt_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rxByte_q, rxByte_d;
  logic             rxDone_q, rxDone_d;
  logic [1:0]       sync_q;
  logic             rxLine;
`ifdef UART_RX_FRAME_ERR_EN
  logic             frameErr_q, frameErr_d;
  logic             badStop_q, badStop_d;
`endif

  assign rxLine = sync_q[1];

  always_ff @(posedge iClk) begin
    if (iRst) begin
      sync_q     <= 2'b11;
      state_q    <= IDLE;
      clkCnt_q   <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      rxByte_q   <= '0;
      rxDone_q   <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      frameErr_q <= 1'b0;
      badStop_q  <= 1'b0;
`endif
    end else begin
      sync_q     <= {sync_q[0], iRxSerial};
      state_q    <= state_d;
      clkCnt_q   <= clkCnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      rxByte_q   <= rxByte_d;
      rxDone_q   <= rxDone_d;
`ifdef UART_RX_FRAME_ERR_EN
      frameErr_q <= frameErr_d;
      badStop_q  <= badStop_d;
`endif
    end
  end

  // START samples once at mid start bit; every later sample lands mid-bit, one bit period apart.
  always_comb begin
    state_d    = state_q;
    clkCnt_d   = clkCnt_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    rxByte_d   = rxByte_q;
    rxDone_d   = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    frameErr_d = 1'b0;
    badStop_d  = badStop_q;
`endif
    case (state_q)
      IDLE: begin
        clkCnt_d = '0;
        if (!rxLine) begin
          bitIdx_d = '0;
          state_d  = START;
        end
      end
      START: begin
        if (clkCnt_q == HALF_END) begin
          clkCnt_d = '0;
          state_d  = rxLine ? IDLE : DATA;
        end else begin
          clkCnt_d = clkCnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (clkCnt_q == BIT_END) begin
          clkCnt_d          = '0;
          shift_d[bitIdx_q] = rxLine;
          if (bitIdx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end else begin
          clkCnt_d = clkCnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (clkCnt_q == BIT_END) begin
          clkCnt_d = '0;
          state_d  = DONE;
`ifdef UART_RX_FRAME_ERR_EN
          badStop_d = !rxLine;
          if (rxLine) begin
            rxByte_d = shift_q;
          end
`else
          rxByte_d = shift_q;
`endif
        end else begin
          clkCnt_d = clkCnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef UART_RX_FRAME_ERR_EN
        if (badStop_q) begin
          frameErr_d = 1'b1;
        end else begin
          rxDone_d = 1'b1;
        end
`else
        rxDone_d = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign oRxByte = rxByte_q;
  assign oRxDone = rxDone_q;
`ifdef UART_RX_FRAME_ERR_EN
  assign oRxFrameErr = frameErr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 10 clocks per bit.
// Honours UART_RX_FRAME_ERR_EN to exercise the framing-error port.
module tb_uart_rx;

  localparam int CPB = 10;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic       iRxSerial = 1'b1;
  logic [7:0] oRxByte;
  logic       oRxDone;
`ifdef UART_RX_FRAME_ERR_EN
  logic       oRxFrameErr;
`endif

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         doneCount = 0;
  int         errCount = 0;
  int         lastDoneCyc = 0;
  logic [7:0] lastDoneByte = 8'h00;
  int         startCyc = 0;
  int         firstCyc = 0;
  logic [7:0] firstByte = 8'h00;

  uart_rx #(
    .CLK_FREQ (100),
    .BAUD_RATE(10)
  ) dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iRxSerial(iRxSerial),
    .oRxByte  (oRxByte),
    .oRxDone  (oRxDone)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .oRxFrameErr(oRxFrameErr)
`endif
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk) cyc <= cyc + 1;

  // Pulse monitor: every high sample counts, so a stretched pulse shows up as an extra count.
  always @(negedge iClk) begin
    if (oRxDone === 1'b1) begin
      doneCount++;
      lastDoneCyc  = cyc;
      lastDoneByte = oRxByte;
    end
`ifdef UART_RX_FRAME_ERR_EN
    if (oRxFrameErr === 1'b1) errCount++;
`endif
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one full 8N1 frame starting at a falling clock edge; returns 10 bit periods later.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
    startCyc  = cyc;
    iRxSerial = 1'b0;
    repeat (CPB) @(negedge iClk);
    for (int i = 0; i < 8; i++) begin
      iRxSerial = data[i];
      repeat (CPB) @(negedge iClk);
    end
    iRxSerial = stopBit;
    repeat (CPB) @(negedge iClk);
    iRxSerial = 1'b1;
  endtask

  initial begin
    iRst = 1'b1;
    repeat (5) @(negedge iClk);
    checkOutput("reset_byte", 32'(oRxByte), 32'h00);
    checkOutput("reset_done", 32'(oRxDone), 32'h0);
`ifdef UART_RX_FRAME_ERR_EN
    checkOutput("reset_ferr", 32'(oRxFrameErr), 32'h0);
`endif
    iRst = 1'b0;
    repeat (5) @(negedge iClk);
    checkOutput("idle_nodone", 32'(doneCount), 32'd0);

    $display("[TB] frame 0x56");
    applyStimulus(8'h56, 1'b1);
    checkOutput("f56_count", 32'(doneCount), 32'd1);
    checkOutput("f56_pulse_byte", 32'(lastDoneByte), 32'h56);
    // 99 rising edges from the drive point: the registering edge plus 98 cycles of latency.
    checkOutput("f56_latency", 32'(lastDoneCyc - startCyc), 32'd99);
    checkOutput("f56_byte", 32'(oRxByte), 32'h56);
    repeat (50) @(negedge iClk);
    checkOutput("f56_quiet_count", 32'(doneCount), 32'd1);
    checkOutput("f56_quiet_done", 32'(oRxDone), 32'h0);

    $display("[TB] 3-cycle glitch");
    iRxSerial = 1'b0;
    repeat (3) @(negedge iClk);
    iRxSerial = 1'b1;
    repeat (30) @(negedge iClk);
    checkOutput("glitch_count", 32'(doneCount), 32'd1);
    checkOutput("glitch_byte", 32'(oRxByte), 32'h56);

    $display("[TB] back-to-back 0xA5, 0x00");
    applyStimulus(8'hA5, 1'b1);
    firstCyc  = lastDoneCyc;
    firstByte = lastDoneByte;
    applyStimulus(8'h00, 1'b1);
    checkOutput("b2b_count", 32'(doneCount), 32'd3);
    checkOutput("b2b_first_byte", 32'(firstByte), 32'hA5);
    checkOutput("b2b_second_byte", 32'(lastDoneByte), 32'h00);
    checkOutput("b2b_spacing", 32'(lastDoneCyc - firstCyc), 32'd100);
    repeat (20) @(negedge iClk);

    $display("[TB] reset during bit 4 of 0xFF");
    applyStimulus(8'h3C, 1'b1);
    checkOutput("pre_abort_byte", 32'(oRxByte), 32'h3C);
    repeat (10) @(negedge iClk);
    iRxSerial = 1'b0;
    repeat (CPB) @(negedge iClk);
    iRxSerial = 1'b1;
    repeat (4 * CPB + 5) @(negedge iClk);
    iRst = 1'b1;
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    repeat (4 * CPB + 20) @(negedge iClk);
    checkOutput("abort_count", 32'(doneCount), 32'd4);
    checkOutput("abort_byte", 32'(oRxByte), 32'h00);
    applyStimulus(8'h3C, 1'b1);
    checkOutput("post_abort_count", 32'(doneCount), 32'd5);
    checkOutput("post_abort_pulse_byte", 32'(lastDoneByte), 32'h3C);
    checkOutput("post_abort_byte", 32'(oRxByte), 32'h3C);
    repeat (20) @(negedge iClk);

    $display("[TB] 0x81 with low stop bit");
    applyStimulus(8'h81, 1'b0);
    repeat (30) @(negedge iClk);
`ifdef UART_RX_FRAME_ERR_EN
    checkOutput("ferr_count", 32'(errCount), 32'd1);
    checkOutput("ferr_done_count", 32'(doneCount), 32'd5);
    checkOutput("ferr_byte", 32'(oRxByte), 32'h3C);
    checkOutput("ferr_idle", 32'(oRxFrameErr), 32'h0);
`else
    checkOutput("nostop_done_count", 32'(doneCount), 32'd6);
    checkOutput("nostop_byte", 32'(oRxByte), 32'h81);
    checkOutput("nostop_errs", 32'(errCount), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
